// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA sequencing controller: FSM state encoding and
// default widths/limits used by the controller and its optional watchdog.
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } rsa_state_t;

  localparam int DEFAULT_WORD_SIZE      = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/rsa_watchdog.sv
// RUN-state cycle counter for the RSA controller; expired flags the last
// permitted RUN cycle so the controller can abort on that edge.
module rsa_watchdog
  import rsa_pkg::*;
#(
  parameter int TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_reg;

  // Counter holds j-1 during the j-th enabled cycle, so expiry lands on cycle TimeoutCycles.
  assign expired = enable && (cnt_reg == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (enable && !expired) begin
      cnt_reg <= cnt_reg + CntW'(1);
    end
  end

endmodule

// File: rtl/rsa_controller.sv
// Load/run sequencer between the host valid/ready ports and the modexp datapath.
// Optional RUN watchdog is compiled in with RSA_CTRL_TIMEOUT_EN.
module rsa_controller
  import rsa_pkg::*;
#(
  parameter int WordSize      = DEFAULT_WORD_SIZE,
  parameter int LoadCycles    = 1,
  parameter int TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WordSize-1:0] in_text,
  input  logic [WordSize-1:0] in_key,
  input  logic [WordSize-1:0] in_mod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WordSize-1:0] out_text,
  output logic                out_error,
  output logic                busy,
  output logic [WordSize-1:0] dp_input_text,
  output logic [WordSize-1:0] dp_key,
  output logic [WordSize-1:0] dp_mod,
  output logic                dp_load,
  output logic                dp_running,
  input  logic                dp_over,
  input  logic [WordSize-1:0] dp_output_text
);

  localparam int LoadCntW = (LoadCycles > 1) ? $clog2(LoadCycles) : 1;

  rsa_state_t          state_reg;
  logic [LoadCntW-1:0] load_cnt_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic                out_error_reg;
  logic                busy_reg;
  logic                dp_load_reg;
  logic                dp_running_reg;
  logic [WordSize-1:0] out_text_reg;
  logic [WordSize-1:0] dp_text_reg;
  logic [WordSize-1:0] dp_key_reg;
  logic [WordSize-1:0] dp_mod_reg;
  logic                run_expired;

`ifdef RSA_CTRL_TIMEOUT_EN
  rsa_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg != ST_RUN),
    .enable (state_reg == ST_RUN),
    .expired(run_expired)
  );
`else
  // Without the watchdog RUN never expires.
  assign run_expired = (TimeoutCycles < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      load_cnt_reg   <= '0;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_error_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      dp_load_reg    <= 1'b0;
      dp_running_reg <= 1'b0;
      out_text_reg   <= '0;
      dp_text_reg    <= '0;
      dp_key_reg     <= '0;
      dp_mod_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready_reg) begin
            dp_text_reg  <= in_text;
            dp_key_reg   <= in_key;
            dp_mod_reg   <= in_mod;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            // A modulus below 2 has no meaningful result; reject without touching the datapath.
            if (in_mod < WordSize'(2)) begin
              state_reg     <= ST_DONE;
              out_valid_reg <= 1'b1;
              out_error_reg <= 1'b1;
              out_text_reg  <= '0;
            end else begin
              state_reg    <= ST_LOAD;
              dp_load_reg  <= 1'b1;
              load_cnt_reg <= '0;
            end
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_cnt_reg == LoadCntW'(LoadCycles - 1)) begin
            state_reg      <= ST_RUN;
            dp_load_reg    <= 1'b0;
            dp_running_reg <= 1'b1;
          end else begin
            load_cnt_reg <= load_cnt_reg + LoadCntW'(1);
          end
        end
        ST_RUN: begin
          if (dp_over) begin
            state_reg      <= ST_DONE;
            dp_running_reg <= 1'b0;
            out_valid_reg  <= 1'b1;
            out_error_reg  <= 1'b0;
            out_text_reg   <= dp_output_text;
          end else if (run_expired) begin
            state_reg      <= ST_DONE;
            dp_running_reg <= 1'b0;
            out_valid_reg  <= 1'b1;
            out_error_reg  <= 1'b1;
            out_text_reg   <= '0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = out_valid_reg;
  assign out_error     = out_error_reg;
  assign out_text      = out_text_reg;
  assign busy          = busy_reg;
  assign dp_load       = dp_load_reg;
  assign dp_running    = dp_running_reg;
  assign dp_input_text = dp_text_reg;
  assign dp_key        = dp_key_reg;
  assign dp_mod        = dp_mod_reg;

endmodule

// File: tb/tb_rsa_controller.sv
// Directed bench for rsa_controller: normal op, backpressure, modulus reject,
// reset mid-RUN, watchdog timeout (with RSA_CTRL_TIMEOUT_EN) and back-to-back sets.
module tb_rsa_controller;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_text;
  logic [31:0] in_key;
  logic [31:0] in_mod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_text;
  logic        out_error;
  logic        busy;
  logic [31:0] dp_input_text;
  logic [31:0] dp_key;
  logic [31:0] dp_mod;
  logic        dp_load;
  logic        dp_running;
  logic        dp_over;
  logic [31:0] dp_output_text;

  int n_vec = 0;
  int n_err = 0;
  int load_pulses = 0;
  int load_high = 0;
  logic load_prev = 1'b0;

  rsa_controller #(
    .WordSize     (32),
    .LoadCycles   (1),
    .TimeoutCycles(100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_text       (in_text),
    .in_key        (in_key),
    .in_mod        (in_mod),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_text      (out_text),
    .out_error     (out_error),
    .busy          (busy),
    .dp_input_text (dp_input_text),
    .dp_key        (dp_key),
    .dp_mod        (dp_mod),
    .dp_load       (dp_load),
    .dp_running    (dp_running),
    .dp_over       (dp_over),
    .dp_output_text(dp_output_text)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count dp_load pulses and high cycles independently of the stimulus.
  always @(negedge clk) begin
    if (dp_load && !load_prev) load_pulses++;
    if (dp_load) load_high++;
    load_prev = dp_load;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] t, input logic [31:0] k, input logic [31:0] m, input string tag);
    int n = 0;
    in_valid = 1'b1;
    in_text  = t;
    in_key   = k;
    in_mod   = m;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check({tag, "_accept_wait"}, 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("send %s text=%0d key=%0d mod=%0d", tag, t, k, m);
  endtask

  // From the LOAD cycle: reach RUN, raise dp_over in RUN cycle dly, check the result.
  task automatic complete_run(input int dly, input logic [31:0] res, input string tag);
    int n = 0;
    while (!dp_running && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_running"}, dp_running, 1);
    repeat (dly - 1) tick();
    check({tag, "_valid_before"}, out_valid, 0);
    dp_over        = 1'b1;
    dp_output_text = res;
    tick();
    dp_over        = 1'b0;
    dp_output_text = '0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_text"}, out_text, res);
    check({tag, "_error"}, out_error, 0);
    check({tag, "_run_drop"}, dp_running, 0);
    $display("result %s out_text=%0d out_error=%0d", tag, out_text, out_error);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_valid_clr"}, out_valid, 0);
  endtask

  task automatic run_full(input logic [31:0] t, input logic [31:0] k, input logic [31:0] m,
                          input int dly, input logic [31:0] res, input string tag);
    int lp0;
    lp0 = load_pulses;
    send(t, k, m, tag);
    check({tag, "_dp_text"}, dp_input_text, t);
    check({tag, "_dp_key"}, dp_key, k);
    check({tag, "_dp_mod"}, dp_mod, m);
    complete_run(dly, res, tag);
    check({tag, "_load_pulses"}, load_pulses, lp0 + 1);
    handshake(tag);
  endtask

  initial begin
    int lp0;
    int lh0;
    int n;
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_text        = '0;
    in_key         = '0;
    in_mod         = '0;
    out_ready      = 1'b0;
    dp_over        = 1'b0;
    dp_output_text = '0;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dp_load", dp_load, 0);
    check("rst_dp_running", dp_running, 0);
    check("rst_out_text", out_text, 0);
    check("rst_out_error", out_error, 0);
    check("rst_dp_mod", dp_mod, 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Normal op with backpressure afterwards
    lp0 = load_pulses;
    lh0 = load_high;
    send(65, 17, 3233, "norm");
    check("norm_load", dp_load, 1);
    check("norm_busy", busy, 1);
    check("norm_in_ready", in_ready, 0);
    check("norm_dp_text", dp_input_text, 65);
    check("norm_dp_key", dp_key, 17);
    check("norm_dp_mod", dp_mod, 3233);
    complete_run(40, 2790, "norm");
    check("norm_load_high", load_high, lh0 + 1);
    check("norm_load_pulses", load_pulses, lp0 + 1);

    in_valid = 1'b1;
    in_text  = 5;
    in_key   = 3;
    in_mod   = 33;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_text", out_text, 2790);
      check("bp_in_ready", in_ready, 0);
      check("bp_dp_mod", dp_mod, 3233);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_valid", out_valid, 0);
    check("bp_hs_in_ready", in_ready, 1);
    check("bp_hs_busy", busy, 0);
    check("bp_hs_not_taken", dp_mod, 3233);
    tick();
    in_valid = 1'b0;
    check("bp_next_mod", dp_mod, 33);
    check("bp_next_load", dp_load, 1);
    complete_run(5, 26, "bp_next");
    handshake("bp_next");
    out_ready = 1'b0;

    // Modulus reject for mod=1 and mod=0
    lp0 = load_pulses;
    send(9, 9, 1, "rej1");
    check("rej1_valid", out_valid, 1);
    check("rej1_error", out_error, 1);
    check("rej1_text", out_text, 0);
    check("rej1_load", dp_load, 0);
    handshake("rej1");
    out_ready = 1'b0;
    send(9, 9, 0, "rej0");
    check("rej0_valid", out_valid, 1);
    check("rej0_error", out_error, 1);
    check("rej0_text", out_text, 0);
    handshake("rej0");
    out_ready = 1'b0;
    check("rej_no_load", load_pulses, lp0);

    // Reset in RUN cycle 20
    send(1, 2, 1000, "rstrun");
    n = 0;
    while (!dp_running && n < 20) begin
      tick();
      n++;
    end
    repeat (19) tick();
    check("rstrun_running", dp_running, 1);
    reset = 1'b1;
    tick();
    check("rstrun_running_clr", dp_running, 0);
    check("rstrun_busy", busy, 0);
    check("rstrun_valid", out_valid, 0);
    check("rstrun_in_ready", in_ready, 0);
    check("rstrun_dp_mod", dp_mod, 0);
    check("rstrun_dp_key", dp_key, 0);
    reset = 1'b0;
    tick();
    check("rstrun_after_valid", out_valid, 0);
    check("rstrun_after_in_ready", in_ready, 1);
    run_full(42, 7, 187, 12, 15, "after_rst");
    out_ready = 1'b0;

`ifdef RSA_CTRL_TIMEOUT_EN
    // Watchdog abort after exactly 100 RUN cycles
    send(3, 3, 55, "tmo");
    n = 0;
    while (!dp_running && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (dp_running && n < 300) begin
      n++;
      tick();
    end
    check("tmo_run_cycles", n, 100);
    check("tmo_valid", out_valid, 1);
    check("tmo_error", out_error, 1);
    check("tmo_text", out_text, 0);
    handshake("tmo");
    out_ready = 1'b0;
`endif

    // dp_over on RUN cycle 100 yields a normal result
    run_full(4, 5, 77, 100, 23, "edge100");

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    lp0 = load_pulses;
    run_full(2, 10, 1000, 3, 24, "b2b_0");
    run_full(3, 4, 50, 4, 31, "b2b_1");
    run_full(7, 2, 10, 2, 9, "b2b_2");
    check("b2b_load_pulses", load_pulses, lp0 + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
